// File: rtl/cdnsusbhs_load_sync_arb.sv
// cdnsusbhs_load_sync_arb: round-robin arbiter feeding the txclk-side load synchronizer with a minimum inter-load gap.
// Define CDNSUSBHS_LOAD_SYNC_ARB_FIXPRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module cdnsusbhs_load_sync_arb #(
   parameter int unsigned DATA_SYNC_WIDTH = 32'd1,
   parameter int unsigned LOAD_GAP        = 32'd8
) (
   input  logic                         txclk,
   input  logic                         txrst,
   input  logic                         arben,
   input  logic [3:0]                   reqload,
   input  logic [4*DATA_SYNC_WIDTH-1:0] reqdata,
   output logic [3:0]                   reqdone,
   output logic [3:0]                   reqovr,
   output logic                         txload,
   output logic [DATA_SYNC_WIDTH-1:0]   txdata,
   output logic                         busy
);
   typedef enum logic {IDLE, GAP} state_t;
   state_t                       state_q, state_d;
   logic [3:0]                   pending_q, pending_d, reqdone_q, reqovr_q, reqovr_d, gnt;
   logic [3:0]                   cnt_q, cnt_d;
   logic [DATA_SYNC_WIDTH-1:0]   hold_q [4];
   logic [DATA_SYNC_WIDTH-1:0]   hold_d [4];
   logic [DATA_SYNC_WIDTH-1:0]   txdata_q, txdata_d;
   logic                         txload_q, busy_q, busy_d, grant;
   logic [1:0]                   win;
`ifndef CDNSUSBHS_LOAD_SYNC_ARB_FIXPRIO_EN
   logic [1:0]                   ptr_q;
`endif
   always_comb begin
      win = 2'd0;
`ifdef CDNSUSBHS_LOAD_SYNC_ARB_FIXPRIO_EN
      for (int k = 3; k >= 0; k--) if (pending_q[k]) win = 2'(k);
`else
      // descending scan so the candidate closest to the pointer is assigned last
      for (int k = 3; k >= 0; k--) if (pending_q[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
`endif
      grant     = (state_q == IDLE) && arben && (|pending_q);
      gnt       = grant ? (4'b0001 << win) : 4'b0000;
      pending_d = (pending_q & ~gnt) | reqload;
      reqovr_d  = reqload & pending_q & ~gnt;
      txdata_d  = grant ? hold_q[win] : txdata_q;
      busy_d    = grant || (state_q == GAP);
      for (int i = 0; i < 4; i++) hold_d[i] = reqload[i] ? reqdata[i*DATA_SYNC_WIDTH +: DATA_SYNC_WIDTH] : hold_q[i];
      state_d   = state_q;
      cnt_d     = cnt_q;
      if (grant) begin
         state_d = GAP;
         cnt_d   = 4'(LOAD_GAP);
      end else if (state_q == GAP) begin
         cnt_d   = cnt_q - 4'd1;
         state_d = (cnt_q == 4'd1) ? IDLE : GAP;
      end
   end
   always_ff @(posedge txclk) begin
      if (txrst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pending_q <= '0;
         hold_q    <= '{default: '0};
         txload_q  <= 1'b0;
         txdata_q  <= '0;
         reqdone_q <= '0;
         reqovr_q  <= '0;
         busy_q    <= 1'b0;
`ifndef CDNSUSBHS_LOAD_SYNC_ARB_FIXPRIO_EN
         ptr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         hold_q    <= hold_d;
         txload_q  <= grant;
         txdata_q  <= txdata_d;
         reqdone_q <= gnt;
         reqovr_q  <= reqovr_d;
         busy_q    <= busy_d;
`ifndef CDNSUSBHS_LOAD_SYNC_ARB_FIXPRIO_EN
         if (grant) ptr_q <= win + 2'd1;
`endif
      end
   end
   assign txload  = txload_q;
   assign txdata  = txdata_q;
   assign reqdone = reqdone_q;
   assign reqovr  = reqovr_q;
   assign busy    = busy_q;
endmodule

// File: tb/tb_cdnsusbhs_load_sync_arb.sv
// tb_cdnsusbhs_load_sync_arb: table-driven directed check of the load-sync arbiter (W=1, LOAD_GAP=8).
module tb_cdnsusbhs_load_sync_arb;
   logic       txclk = 1'b0;
   logic       txrst = 1'b1;
   logic       arben = 1'b1;
   logic [3:0] reqload = '0;
   logic [3:0] reqdata = '0;
   logic [3:0] reqdone, reqovr;
   logic       txload, busy;
   logic [0:0] txdata;
   int         total = 0;
   int         passed = 0;

   cdnsusbhs_load_sync_arb dut (
      .txclk(txclk), .txrst(txrst), .arben(arben), .reqload(reqload), .reqdata(reqdata),
      .reqdone(reqdone), .reqovr(reqovr), .txload(txload), .txdata(txdata), .busy(busy)
   );

   always #5 txclk = ~txclk;

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] ld;
      logic [3:0] d;
      int         n;
      logic       e_ld;
      logic       e_d;
      logic [3:0] e_done;
      logic [3:0] e_ovr;
      logic       e_busy;
   } vec_t;
   vec_t v[$];

   function automatic void add(logic rst, logic en, logic [3:0] ld, logic [3:0] d, int n,
                               logic e_ld, logic e_d, logic [3:0] e_done, logic [3:0] e_ovr, logic e_busy);
      vec_t r;
      r.rst = rst; r.en = en; r.ld = ld; r.d = d; r.n = n;
      r.e_ld = e_ld; r.e_d = e_d; r.e_done = e_done; r.e_ovr = e_ovr; r.e_busy = e_busy;
      v.push_back(r);
   endfunction

   task automatic check(string name, logic [10:0] got, logic [10:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got {ld,d,done,ovr,busy}=%b required %b", name, got, exp);
   endtask

   initial begin
      int last, npulse;
      // reset
      add(1,1,4'b0000,4'b0000,2, 0,0,4'b0000,4'b0000,0);
      // single request from requester 2
      add(0,1,4'b0100,4'b0100,1, 0,0,4'b0000,4'b0000,0);
      add(0,1,4'b0000,4'b0000,1, 1,1,4'b0100,4'b0000,1);
      add(0,1,4'b0000,4'b0000,8, 0,1,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,3, 0,1,4'b0000,4'b0000,0);
      // all four at once after reset (pointer back to 0)
      add(1,1,4'b0000,4'b0000,1, 0,0,4'b0000,4'b0000,0);
      add(0,1,4'b1111,4'b1010,1, 0,0,4'b0000,4'b0000,0);
      add(0,1,4'b0000,4'b0000,1, 1,0,4'b0001,4'b0000,1);
      add(0,1,4'b0000,4'b0000,8, 0,0,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,1, 1,1,4'b0010,4'b0000,1);
      add(0,1,4'b0000,4'b0000,8, 0,1,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,1, 1,0,4'b0100,4'b0000,1);
      add(0,1,4'b0000,4'b0000,8, 0,0,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,1, 1,1,4'b1000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,8, 0,1,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,2, 0,1,4'b0000,4'b0000,0);
      // overrun of requester 1 during a gap
      add(0,1,4'b0001,4'b0001,1, 0,1,4'b0000,4'b0000,0);
      add(0,1,4'b0000,4'b0000,1, 1,1,4'b0001,4'b0000,1);
      add(0,1,4'b0010,4'b0000,1, 0,1,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,1, 0,1,4'b0000,4'b0000,1);
      add(0,1,4'b0010,4'b0010,1, 0,1,4'b0000,4'b0010,1);
      add(0,1,4'b0000,4'b0000,5, 0,1,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,1, 1,1,4'b0010,4'b0000,1);
      add(0,1,4'b0000,4'b0000,8, 0,1,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,2, 0,1,4'b0000,4'b0000,0);
      // coincident capture and grant on requester 0
      add(0,1,4'b0001,4'b0000,1, 0,1,4'b0000,4'b0000,0);
      add(0,1,4'b0001,4'b0001,1, 1,0,4'b0001,4'b0000,1);
      add(0,1,4'b0000,4'b0000,8, 0,0,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,1, 1,1,4'b0001,4'b0000,1);
      add(0,1,4'b0000,4'b0000,8, 0,1,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,2, 0,1,4'b0000,4'b0000,0);
      // arben low holds requests; pointer is 1 so requester 1 goes first
      add(0,0,4'b0011,4'b0010,1, 0,1,4'b0000,4'b0000,0);
      add(0,0,4'b0000,4'b0000,20,0,1,4'b0000,4'b0000,0);
      add(0,1,4'b0000,4'b0000,1, 1,1,4'b0010,4'b0000,1);
      add(0,1,4'b0000,4'b0000,8, 0,1,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,1, 1,0,4'b0001,4'b0000,1);
      add(0,1,4'b0000,4'b0000,8, 0,0,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,2, 0,0,4'b0000,4'b0000,0);
      // reset three cycles into a gap, with requester 3 pending
      add(0,1,4'b0100,4'b0100,1, 0,0,4'b0000,4'b0000,0);
      add(0,1,4'b0000,4'b0000,1, 1,1,4'b0100,4'b0000,1);
      add(0,1,4'b1000,4'b1000,1, 0,1,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,1, 0,1,4'b0000,4'b0000,1);
      add(1,1,4'b0000,4'b0000,1, 0,0,4'b0000,4'b0000,0);
      add(0,1,4'b0000,4'b0000,3, 0,0,4'b0000,4'b0000,0);
      add(0,1,4'b0001,4'b0001,1, 0,0,4'b0000,4'b0000,0);
      add(0,1,4'b0000,4'b0000,1, 1,1,4'b0001,4'b0000,1);
      add(0,1,4'b0000,4'b0000,8, 0,1,4'b0000,4'b0000,1);
      add(0,1,4'b0000,4'b0000,2, 0,1,4'b0000,4'b0000,0);

      @(posedge txclk); #1;
      foreach (v[r]) begin
         txrst = v[r].rst; arben = v[r].en; reqload = v[r].ld; reqdata = v[r].d;
         for (int c = 0; c < v[r].n; c++) begin
            @(posedge txclk); #1;
            reqload = '0;
            check($sformatf("row%0d.cyc%0d", r, c), {txload, txdata, reqdone, reqovr, busy},
                  {v[r].e_ld, v[r].e_d, v[r].e_done, v[r].e_ovr, v[r].e_busy});
         end
      end

      // continuous demand: pulses exactly LOAD_GAP+1 apart
      txrst = 1'b1; reqload = '0;
      @(posedge txclk); #1;
      txrst = 1'b0; last = -1; npulse = 0;
      for (int i = 0; i < 60; i++) begin
         reqload = 4'b1111; reqdata = 4'b0110;
         @(posedge txclk); #1;
         if (txload) begin
            if (last >= 0) check($sformatf("spacing%0d", npulse), 11'(i - last), 11'd9);
            else check("first_latency", 11'(i), 11'd1);
            last = i; npulse++;
         end
      end
      reqload = '0;
      check("pulse_count", 11'(npulse), 11'd7);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/cdnsusbhs_load_sync_arb.md
Name: cdnsusbhs_load_sync_arb

Overview:
- Transmit-side controller for the load synchronizer in the txclk domain.
- Collects load requests from 4 independent requesters.
- Holds each request's data in a per-requester holding register and grants requests round-robin.
- Drives the synchronizer's txload/txdata, with a programmable minimum gap between loads so each CDC req/ack round trip completes before the next load.

Parameters:
- DATA_SYNC_WIDTH, 32'd1, width of each requester's data and of txdata.
- LOAD_GAP, 32'd8, idle cycles enforced after each txload pulse; legal range 1..15; gap counter is 4 bits.

Ports:
- txclk  input  1  clock; all logic on rising edge.
- txrst  input  1  reset, synchronous, active-high.
- arben  input  1  grant enable; 0 = no new grants, pending requests retained.
- reqload  input  4  per-requester single-cycle load pulse.
- reqdata  input  4*DATA_SYNC_WIDTH  requester i data at [i*W +: W], sampled when reqload[i]=1.
- reqdone  output  4  one-hot, 1-cycle pulse when requester i's data is issued on txload.
- reqovr  output  4  1-cycle pulse: pending request of requester i overwritten before issue.
- txload  output  1  1-cycle load pulse to the synchronizer.
- txdata  output  DATA_SYNC_WIDTH  data to the synchronizer, valid with txload.
- busy  output  1  1 while txload=1 or in GAP state.

Behaviour:
- Reset (txrst=1 at edge), regardless of state:
  - txload, reqdone, reqovr, busy, txdata = 0.
  - pending[3:0] = 0, holding registers = 0, round-robin pointer = 0, gap counter = 0, state IDLE.
  - An in-progress GAP is abandoned.
- Capture: reqload[i] at edge N sets pending[i] and hold[i] <= reqdata slice i.
- Overrun:
  - reqload[i] while pending[i]=1 and i not granted that cycle: hold[i] is overwritten, pending stays 1, reqovr[i]=1 at cycle N+1.
  - Only the newest data is issued.
- Coincident capture and grant: reqload[i] in the same cycle i is granted.
  - The grant uses the old hold[i].
  - The new data is captured and pending[i] stays 1 for a later grant.
  - No reqovr.
- FSM, 2 states:
  - IDLE: if arben=1 and pending!=0, select winner w.
    - txload<=1, txdata<=hold[w], reqdone[w]<=1, pending[w]<=0, pointer<=(w+1) mod 4, gap counter<=LOAD_GAP, state<=GAP.
    - Otherwise txload=0 and txdata holds its last value.
  - GAP: txload=0, counter decrements each cycle; at counter==1 the state returns to IDLE next edge.
    - arben and new requests do not shorten or extend the gap.
- Round robin: search order pointer, pointer+1, … mod 4; first pending index wins.
- Latency:
  - reqload at edge N; earliest txload/reqdone asserted after edge N+1, i.e. pending is visible one cycle later.
  - Consecutive txload pulses are at least LOAD_GAP+1 cycles apart, exactly that with continuous demand.
- arben deassertion: takes effect on the next IDLE decision and does not cancel a GAP. Requests captured while arben=0 are retained and granted after re-enable.
- busy = txload OR (state==GAP); registered.
- Widths: pointer 2 bits, wraps 3->0; counter 4 bits, loaded with LOAD_GAP[3:0].

Optional Feature:
- Macro CDNSUSBHS_LOAD_SYNC_ARB_FIXPRIO_EN.
- Defined: fixed priority, requester 0 highest and 3 lowest. The pointer register is removed and reqdone timing is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single request: reqload=4'b0100, reqdata slice 2=0x1 at edge 0, LOAD_GAP=8 -> txload=1, txdata=0x1, reqdone=4'b0100 two cycles later; busy high 9 cycles; no other txload.
- All four: reqload=4'b1111 in one cycle, data 0x0/0x1/0x0/0x1 (W=1) -> txload issues requesters 0,1,2,3 in order, pulses exactly 9 cycles apart, reqdone one-hot in matching order.
- Overrun: requester 1 pulses reqload with data 0 then 1 during GAP -> reqovr=4'b0010 one cycle after the second pulse; requester 1 is issued once with txdata=1.
- Coincident: reqload[0] in the same cycle requester 0 is granted -> old data issued, requester 0 issued again after the gap with new data, reqovr stays 0.
- arben=0 with pending=4'b0011 for 20 cycles -> no txload. After arben=1, issue follows the pointer order.
- Reset mid-GAP: txrst=1 for one cycle 3 cycles after txload -> all outputs 0, pending cleared. A new request after reset issues with no residual gap, txload two cycles after reqload.
